// File: rtl/sp_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// sp_mem_access_ctrl
//
// Arbitrates a write request channel and a read request channel onto a
// single-port RAM and returns read data, in request order, through a small
// response FIFO. Reads are only issued when a response slot is guaranteed,
// so the FIFO can never overflow and the RAM pipeline never needs stalling.
//
// Optional feature macro: SP_MEM_ACCESS_CTRL_RR_ARB_EN
//   undefined -> fixed write priority
//   defined   -> alternating (round-robin) grant when both channels contend
//
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data   write request channel
//   rd_valid/rd_ready/rd_addr           read request channel
//   resp_valid/resp_ready/resp_data     read response channel
//   mem_addr/mem_din/mem_en/mem_we/mem_regcea/mem_dout  RAM master side
// ---------------------------------------------------------------------------
module sp_mem_access_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic                  mem_regcea,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int CW = $clog2(RESP_DEPTH) + 1;
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic                    credit;
    logic                    wr_grant;
    logic                    rd_grant;
    logic [READ_LATENCY-1:0] vld_sr;
    logic [READ_LATENCY-1:0] vld_sr_next;
    logic                    push;
    logic                    pop;
    logic [CW-1:0]           in_flight;
    logic [CW-1:0]           fifo_count;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [DATA_WIDTH-1:0]   fifo_mem [RESP_DEPTH];

    // A read may only be issued if a FIFO slot is reserved for its data,
    // counting both reads still inside the RAM pipeline and queued responses.
    // One extra bit on the sum keeps the compare overflow-free.
    assign credit = ({1'b0, in_flight} + {1'b0, fifo_count}) < (CW + 1)'(RESP_DEPTH);

`ifdef SP_MEM_ACCESS_CTRL_RR_ARB_EN
    typedef enum logic {
        LAST_WR = 1'b0,
        LAST_RD = 1'b1
    } last_grant_t;

    last_grant_t last_grant;

    // Under contention the channel that did not win last time gets the grant;
    // an uncontested request is granted straight away.
    always_comb begin
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        if (rst) begin
            wr_ready = !(rd_valid && credit) || (last_grant == LAST_RD);
            rd_ready = credit && (!wr_valid || (last_grant == LAST_WR));
        end
    end

    // Remember which channel was granted most recently.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= LAST_RD;
        end else if (wr_grant) begin
            last_grant <= LAST_WR;
        end else if (rd_grant) begin
            last_grant <= LAST_RD;
        end
    end
`else
    // Writes always win; a read only goes when no write is pending.
    always_comb begin
        wr_ready = rst;
        rd_ready = rst && !wr_valid && credit;
    end
`endif

    assign wr_grant = wr_valid && wr_ready;
    assign rd_grant = rd_valid && rd_ready;

    // Drive the RAM directly from the granted request so it sees the access
    // in the same cycle as the handshake.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (wr_grant) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = wr_addr;
            mem_din  = wr_data;
        end else if (rd_grant) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
        end
    end

    assign mem_regcea = rst;

    // Each issued read travels down a shift register matching the RAM read
    // latency; the bit leaving the top marks the cycle mem_dout is valid.
    always_comb begin
        vld_sr_next    = vld_sr << 1;
        vld_sr_next[0] = rd_grant;
    end

    assign push       = vld_sr[READ_LATENCY-1];
    assign resp_valid = rst && (fifo_count != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_data  = fifo_mem[rd_ptr];

    // Pipeline tracking, credit counters and FIFO pointers. Clearing the
    // shift register on reset drops any read still inside the RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_sr     <= '0;
            in_flight  <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            vld_sr     <= vld_sr_next;
            in_flight  <= in_flight + CW'(rd_grant) - CW'(push);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Response storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo_mem[wr_ptr] <= mem_dout;
        end
    end

endmodule

// File: tb/tb_sp_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sp_mem_access_ctrl
//
// Drives sp_mem_access_ctrl against a behavioural single-port RAM with a
// READ_LATENCY-deep read pipeline. A monitor pushes the expected read data
// into a queue on every accepted read and checks it when the response
// channel hands data over. Honours SP_MEM_ACCESS_CTRL_RR_ARB_EN.
// ---------------------------------------------------------------------------
module tb_sp_mem_access_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int RL = 2;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_en;
    logic          mem_we;
    logic          mem_regcea;
    logic [DW-1:0] mem_dout;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic [DW-1:0] ram     [2**AW];
    logic [DW-1:0] exp_mem [2**AW];
    logic [DW-1:0] pipe    [RL];
    int            resp_count     = 0;
    int            first_resp_cyc = 0;
    int            last_resp_cyc  = 0;

    sp_mem_access_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL),
        .RESP_DEPTH  (RD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_regcea(mem_regcea),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: synchronous read into stage 0, then output registers.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_din;
        end
        if (mem_en && !mem_we) begin
            pipe[0] <= ram[mem_addr];
        end
        if (mem_regcea) begin
            for (int k = 1; k < RL; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign mem_dout = pipe[RL-1];

    // Scoreboard monitor, sampling mid-cycle so every handshake is stable.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
        end else begin
            if (resp_valid && resp_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL resp_unexpected: got data %h, expected no response", resp_data);
                end else begin
                    e = sb.pop_front();
                    if (resp_data !== e.data) begin
                        miscompares++;
                        $display("[TB] FAIL resp_data: got %h, expected %h", resp_data, e.data);
                    end
                    vectors++;
                    if (cyc - e.cyc < RL + 1) begin
                        miscompares++;
                        $display("[TB] FAIL resp_latency: got %0d cycles, expected >= %0d", cyc - e.cyc, RL + 1);
                    end
                end
                if (resp_count == 0) first_resp_cyc = cyc;
                last_resp_cyc = cyc;
                resp_count++;
            end
            if (wr_valid && wr_ready) begin
                exp_mem[wr_addr] = wr_data;
            end
            if (rd_valid && rd_ready) begin
                sb.push_back('{exp_mem[rd_addr], cyc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(output bit ok);
        int n;
        n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 100) begin
            step();
            n++;
        end
        ok = (sb.size() == 0) && !resp_valid;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        wr_valid   = 1'b1;
        rd_valid   = 1'b1;
        wr_addr    = 8'h33;
        wr_data    = 8'h44;
        rd_addr    = 8'h55;
        resp_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        vectors++;
        if ({wr_ready, rd_ready, resp_valid} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b, expected 000", {wr_ready, rd_ready, resp_valid});
        end
        vectors++;
        if ({mem_en, mem_we, mem_regcea} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_mem_ctrl: got %b, expected 000", {mem_en, mem_we, mem_regcea});
        end
        vectors++;
        if ({mem_addr, mem_din} !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_mem_bus: got %h, expected 0000", {mem_addr, mem_din});
        end
        step();
        rst      = 1'b1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_regcea, resp_valid, mem_en, wr_ready, rd_ready} !== 5'b10011) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: got %b, expected 10011",
                     {mem_regcea, resp_valid, mem_en, wr_ready, rd_ready});
        end
    endtask

    task automatic test_write_read();
        int n;
        step();
        wr_valid   = 1'b1;
        wr_addr    = 8'h10;
        wr_data    = 8'hA5;
        resp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({wr_ready, mem_en, mem_we, mem_addr, mem_din} !== {3'b111, 8'h10, 8'hA5}) begin
            miscompares++;
            $display("[TB] FAIL write_grant: got %b %h %h, expected 111 10 a5",
                     {wr_ready, mem_en, mem_we}, mem_addr, mem_din);
        end
        step();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 8'h10;
        @(negedge clk);
        vectors++;
        if ({rd_ready, mem_en, mem_we, mem_addr} !== {3'b110, 8'h10}) begin
            miscompares++;
            $display("[TB] FAIL read_grant: got %b %h, expected 110 10",
                     {rd_ready, mem_en, mem_we}, mem_addr);
        end
        step();
        rd_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (n != RL + 1) begin
            miscompares++;
            $display("[TB] FAIL read_latency: got %0d cycles, expected %0d", n, RL + 1);
        end
        vectors++;
        if (resp_data !== 8'hA5) begin
            miscompares++;
            $display("[TB] FAIL write_then_read: got %h, expected a5", resp_data);
        end
    endtask

    task automatic test_credit();
        int nxt;
        int acc;
        bit ok;
        step();
        resp_ready = 1'b0;
        resp_count = 0;
        nxt = 0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            rd_valid = 1'b1;
            rd_addr  = 8'(8'h20 + nxt);
            @(negedge clk);
            if (rd_ready) begin
                acc++;
                nxt++;
            end
            step();
        end
        vectors++;
        if (acc != RD) begin
            miscompares++;
            $display("[TB] FAIL credit_accepts: got %0d, expected %0d", acc, RD);
        end
        @(negedge clk);
        vectors++;
        if (rd_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL credit_block: rd_ready got %b, expected 0", rd_ready);
        end
        step();
        resp_ready = 1'b1;
        for (int i = 0; i < 60 && nxt < 8; i++) begin
            rd_valid = 1'b1;
            rd_addr  = 8'(8'h20 + nxt);
            @(negedge clk);
            if (rd_ready) nxt++;
            step();
        end
        rd_valid = 1'b0;
        vectors++;
        if (nxt != 8) begin
            miscompares++;
            $display("[TB] FAIL credit_resume: got %0d reads accepted, expected 8", nxt);
        end
        drain(ok);
        vectors++;
        if (!ok || resp_count != 8) begin
            miscompares++;
            $display("[TB] FAIL credit_drain: got %0d responses, expected 8", resp_count);
        end
    endtask

    task automatic test_contention();
        int wn;
        int rn;
        bit first_wr;
        bit ok;
        step();
        resp_ready = 1'b1;
        wn = 0;
        rn = 0;
        first_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 8'(8'h40 + wn);
            wr_data  = 8'(8'hC0 + wn);
            rd_valid = 1'b1;
            rd_addr  = 8'(8'h80 + rn);
            @(negedge clk);
            if (i == 0) first_wr = wr_ready;
            if (wr_ready) wn++;
            if (rd_ready) rn++;
            step();
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
`ifdef SP_MEM_ACCESS_CTRL_RR_ARB_EN
        vectors++;
        if (wn != 3 || rn != 3) begin
            miscompares++;
            $display("[TB] FAIL contention_split: got %0d wr %0d rd, expected 3 wr 3 rd", wn, rn);
        end
`else
        vectors++;
        if (wn != 6 || rn != 0) begin
            miscompares++;
            $display("[TB] FAIL contention_split: got %0d wr %0d rd, expected 6 wr 0 rd", wn, rn);
        end
`endif
        vectors++;
        if (first_wr !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL contention_first: got write-first %b, expected 1", first_wr);
        end
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL contention_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_inflight();
        int acc;
        bit ok;
        step();
        resp_ready = 1'b1;
        rd_valid   = 1'b1;
        rd_addr    = 8'h05;
        step();
        rd_addr    = 8'h06;
        step();
        rd_valid   = 1'b0;
        rst        = 1'b0;
        repeat (2) step();
        rst        = 1'b1;
        resp_count = 0;
        for (int i = 0; i < RL + 3; i++) begin
            @(negedge clk);
            vectors++;
            if (resp_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_discard: resp_valid got %b, expected 0", resp_valid);
            end
            step();
        end
        resp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            rd_valid = 1'b1;
            rd_addr  = 8'(8'h30 + acc);
            @(negedge clk);
            if (rd_ready) acc++;
            step();
        end
        rd_valid = 1'b0;
        vectors++;
        if (acc != RD) begin
            miscompares++;
            $display("[TB] FAIL reset_credit: got %0d reads accepted, expected %0d", acc, RD);
        end
        resp_ready = 1'b1;
        drain(ok);
        vectors++;
        if (!ok || resp_count != RD) begin
            miscompares++;
            $display("[TB] FAIL reset_recover: got %0d responses, expected %0d", resp_count, RD);
        end
    endtask

    task automatic test_streaming();
        int nxt;
        int used;
        bit ok;
        step();
        resp_ready = 1'b1;
        resp_count = 0;
        nxt  = 0;
        used = 0;
        while (nxt < 64 && used < 200) begin
            rd_valid = 1'b1;
            rd_addr  = 8'(nxt);
            @(negedge clk);
            if (rd_ready) nxt++;
            step();
            used++;
        end
        rd_valid = 1'b0;
        vectors++;
        if (used != 64) begin
            miscompares++;
            $display("[TB] FAIL stream_issue: got %0d cycles for 64 reads, expected 64", used);
        end
        drain(ok);
        vectors++;
        if (!ok || resp_count != 64) begin
            miscompares++;
            $display("[TB] FAIL stream_count: got %0d responses, expected 64", resp_count);
        end
        vectors++;
        if (last_resp_cyc - first_resp_cyc != 63) begin
            miscompares++;
            $display("[TB] FAIL stream_rate: got span %0d cycles, expected 63",
                     last_resp_cyc - first_resp_cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            ram[i]     = 8'(i) ^ 8'h5A;
            exp_mem[i] = 8'(i) ^ 8'h5A;
        end
        for (int k = 0; k < RL; k++) begin
            pipe[k] = '0;
        end
        test_reset();
        test_write_read();
        test_credit();
        test_contention();
        test_reset_inflight();
        test_streaming();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
